multiword_add_seq: RTL
======================

# multiword_add_seq

Multi-cycle, multi-precision add/subtract sequencer that time-shares one `WIDTH`-bit `ripple_carry_adder` to add or subtract operands `WORDS*WIDTH` bits wide. It processes one word per cycle, least-significant word first, and registers the carry between words. It takes operands through a valid/ready input handshake and returns the result through a valid/ready output handshake. It sits between a wide-arithmetic requester and the narrow adder datapath, trading latency for area.

## Interface
- `WIDTH`, 16: adder word width in bits; must be ≥ 1.
- `WORDS`, 4: words per operand; must be ≥ 1. Total operand width is `N = WORDS*WIDTH`.
- `clk` in 1: the single clock; all state is updated on its rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `in_valid` in 1: operand request is valid.
- `in_ready` out 1: the block can accept a request.
- `a_i` in N: operand A.
- `b_i` in N: operand B.
- `cin_i` in 1: carry-in for add; ignored when `sub_i`=1.
- `sub_i` in 1: 1 computes A−B, 0 computes A+B+cin.
- `out_valid` out 1: result is valid.
- `out_ready` in 1: the consumer accepts the result.
- `sum_o` out N: result.
- `cout_o` out 1: final carry-out. For subtract, 1 means no borrow.
- `ovf_o` out 1: signed two's-complement overflow.
- `busy_o` out 1: high whenever state ≠ IDLE.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`:
    - latch `a_i`;
    - latch `b_eff` = `sub_i` ? ~`b_i` : `b_i`;
    - set the carry register to `sub_i` ? 1 : `cin_i`;
    - set word index `idx`=0;
    - go to RUN.
- **RUN**
  - Each cycle, the adder receives word `idx` of A, word `idx` of `b_eff`, and the carry register.
  - The adder sum is written to word `idx` of the result register, and the adder cout is written to the carry register.
  - If `idx`==`WORDS-1`, go to DONE; otherwise `idx`++.
- **DONE**
  - `out_valid`=1.
  - `cout_o` = carry register.
  - `ovf_o` = (A[N-1]==`b_eff`[N-1]) && (sum[N-1]≠A[N-1]), registered at the final RUN cycle.
  - On `out_valid`&`out_ready`, go to IDLE.
- `in_ready`=0 in RUN and DONE. `in_valid` is ignored there; no request is queued.
- `sum_o`, `cout_o` and `ovf_o` are driven from registers.
  - They hold stable throughout DONE, including under backpressure.
  - They retain their last values in IDLE.
  - They are undefined-free, i.e. never X after reset.
- Arithmetic is modulo 2^N. There is no saturation.
- **Reset** (asynchronous, any state, including mid-RUN):
  - state=IDLE, `idx`=0, carry=0;
  - `sum_o`=0, `cout_o`=0, `ovf_o`=0;
  - `out_valid`=0, `busy_o`=0, `in_ready`=1 after reset.
  - Any in-flight operation is discarded.
- `WORDS`=1 degenerates to a single RUN cycle.

## Timing
- Acceptance happens at edge T0.
- RUN occupies the cycles after edges T0 … T0+`WORDS`-1.
- `out_valid` rises after edge T0+`WORDS`, i.e. `WORDS` cycles of latency from acceptance.
- The output handshake at edge Tk returns the block to IDLE. The next acceptance is possible at edge Tk+1.
- Minimum issue interval is `WORDS`+2 cycles per operation.
- `in_ready`, `out_valid` and `busy_o` are decoded from state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- The combinational path per cycle is one `WIDTH`-bit ripple plus the carry-register setup.

## Structure
- Shared package `multiword_add_pkg` contains:
  - the state enum `mwa_state_t` {IDLE, RUN, DONE};
  - function `idx_w(words)` = max(1, $clog2(words)), used for the index width.
- The sub-module is `ripple_carry_adder #(.WIDTH(WIDTH))`, one instance. It is the only arithmetic in the block.
- Word select uses indexed part-select `[idx*WIDTH +: WIDTH]`.

## Test plan
All scenarios use `WIDTH`=16, `WORDS`=4.
- **Carry across words:** add 0x0000_0000_0000_FFFF + 0x1, cin=0 → `sum_o`=0x0000_0000_0001_0000, cout=0, ovf=0, `out_valid` exactly 4 cycles after acceptance.
- **Full wrap:** add 0xFFFF_FFFF_FFFF_FFFF + 0x1 → sum=0, cout=1, ovf=0.
- **Subtract:**
  - 5 − 7 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
  - 0x8000_0000_0000_0000 − 1 → sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
- **Backpressure:** hold `out_ready`=0 for 3 cycles in DONE while driving a second `in_valid` → outputs stable, `in_ready`=0, second request not accepted until the cycle after the output handshake.
- **Reset mid-RUN:** assert `rst` at idx=2 → all outputs at reset values immediately. A following add of 1+1 yields 2 with correct latency.
- **Back-to-back:** `out_ready` tied high with two queued requests → issue interval exactly 6 cycles, both results correct.

Source files
------------

// File: rtl/multiword_add_pkg.sv
// -----------------------------------------------------------------------------
// multiword_add_pkg
// Shared types and helpers for the multi-word add/subtract sequencer.
//   mwa_state_t : sequencer state (IDLE, RUN, DONE)
//   idx_w()     : width of the word-index register, never less than one bit
// -----------------------------------------------------------------------------
package multiword_add_pkg;

    // Sequencer state: waiting for a request, stepping words, holding a result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mwa_state_t;

    // Index width for a given word count; a single-word build still needs one bit
    function automatic int unsigned idx_w(input int unsigned words);
        int unsigned w;
        w = $clog2(words);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : multiword_add_pkg

// File: rtl/ripple_carry_adder.sv
// -----------------------------------------------------------------------------
// ripple_carry_adder
// Purely combinational WIDTH-bit ripple-carry adder built from a chain of
// full-adder cells. The sequencer shares one of these across all words.
// Ports:
//   a_i    [WIDTH-1:0] in  : addend A
//   b_i    [WIDTH-1:0] in  : addend B
//   cin_i              in  : carry into bit 0
//   sum_o  [WIDTH-1:0] out : A + B + cin, modulo 2^WIDTH
//   cout_o             out : carry out of the top bit
// -----------------------------------------------------------------------------
module ripple_carry_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    // Carry chain: w_carry[i] enters bit i, w_carry[WIDTH] leaves the top bit
    logic [WIDTH:0] w_carry;

    assign w_carry[0] = cin_i;

    // One full-adder cell per bit
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_prop;
        assign w_prop         = a_i[i] ^ b_i[i];
        assign sum_o[i]       = w_prop ^ w_carry[i];
        assign w_carry[i + 1] = (a_i[i] & b_i[i]) | (w_prop & w_carry[i]);
    end

    assign cout_o = w_carry[WIDTH];

endmodule : ripple_carry_adder

// File: rtl/multiword_add_seq.sv
// -----------------------------------------------------------------------------
// multiword_add_seq
// Multi-precision add/subtract sequencer. One WIDTH-bit ripple_carry_adder is
// time-shared over WORDS words, least-significant word first, with the carry
// held in a register between words. Operands arrive on a valid/ready request
// handshake; the result leaves on a valid/ready response handshake.
// Ports (N = WORDS*WIDTH):
//   clk              in  : clock, rising edge
//   rst              in  : asynchronous reset, active high
//   in_valid         in  : request valid
//   in_ready         out : request may be accepted (IDLE only)
//   a_i      [N-1:0] in  : operand A
//   b_i      [N-1:0] in  : operand B
//   cin_i            in  : carry-in for add, ignored for subtract
//   sub_i            in  : 1 = A-B, 0 = A+B+cin
//   out_valid        out : result valid (DONE only)
//   out_ready        in  : consumer takes the result
//   sum_o    [N-1:0] out : result, modulo 2^N
//   cout_o           out : final carry; for subtract 1 means no borrow
//   ovf_o            out : signed two's-complement overflow
//   busy_o           out : any state other than IDLE
// -----------------------------------------------------------------------------
module multiword_add_seq
    import multiword_add_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORDS*WIDTH-1:0]   a_i,
    input  logic [WORDS*WIDTH-1:0]   b_i,
    input  logic                     cin_i,
    input  logic                     sub_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORDS*WIDTH-1:0]   sum_o,
    output logic                     cout_o,
    output logic                     ovf_o,
    output logic                     busy_o
);

    localparam int unsigned N     = WORDS * WIDTH;
    localparam int unsigned IDX_W = idx_w(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    // Sequencer state and datapath registers
    mwa_state_t       r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b_eff;
    logic [N-1:0]     r_sum;
    logic             r_cout;
    logic             r_ovf;

    // Handshake/status flags, kept as registers that track the state
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    // Word slice currently feeding the shared adder
    logic [WIDTH-1:0] w_a_word;
    logic [WIDTH-1:0] w_b_word;
    logic [WIDTH-1:0] w_sum_word;
    logic             w_cout_word;
    logic             w_last_word;
    logic             w_ovf_final;

    assign w_a_word    = r_a[32'(r_idx) * WIDTH +: WIDTH];
    assign w_b_word    = r_b_eff[32'(r_idx) * WIDTH +: WIDTH];
    assign w_last_word = (r_idx == LAST_IDX);

    // Overflow when both operands share a sign the final sum does not
    assign w_ovf_final = (r_a[N-1] == r_b_eff[N-1]) && (w_sum_word[WIDTH-1] != r_a[N-1]);

    // The only arithmetic in the block
    ripple_carry_adder #(
        .WIDTH (WIDTH)
    ) u_rca (
        .a_i    (w_a_word),
        .b_i    (w_b_word),
        .cin_i  (r_carry),
        .sum_o  (w_sum_word),
        .cout_o (w_cout_word)
    );

    // Sequencer: accept, step one word per cycle, then hold the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b_eff     <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        // Subtract is A + ~B + 1, so invert B and force carry-in
                        r_a        <= a_i;
                        r_b_eff    <= sub_i ? ~b_i : b_i;
                        r_carry    <= sub_i ? 1'b1 : cin_i;
                        r_idx      <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end

                RUN: begin
                    r_sum[32'(r_idx) * WIDTH +: WIDTH] <= w_sum_word;
                    r_carry                            <= w_cout_word;
                    if (w_last_word) begin
                        r_cout      <= w_cout_word;
                        r_ovf       <= w_ovf_final;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy_o    = r_busy;
    assign sum_o     = r_sum;
    assign cout_o    = r_cout;
    assign ovf_o     = r_ovf;

endmodule : multiword_add_seq
